mips_multicycle_control: RTL and testbench

Multicycle control unit for the MIPS datapath. It sits directly upstream of the ALU. Each cycle it sequences the fetch, decode and execute states, selects the ALU operands and drives the 3-bit ALU `Control` code. It uses the ALU `Zero` flag to resolve `beq`, and it handles a memory ready/wait handshake. It also keeps a count of retired instructions.

---
 rtl/mips_multicycle_control.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute, drives datapath
// mux selects and ALU operation, and counts retired instructions.
module mips_multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic [5:0]             Opcode,
    input  logic [5:0]             Funct,
    input  logic                   Zero,
    input  logic                   MemReady,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUControl,
    output logic [1:0]             PCSource,
    output logic                   PCEn,
    output logic                   Illegal,
    output logic [3:0]             State,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic funct_valid(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_valid = 1'b1;
            default:                               funct_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    // FETCH as the decode target doubles as the "unsupported instruction" marker.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_LW, OP_SW: decode_target = MEMADR;
            OP_RTYPE:     decode_target = funct_valid(fn) ? EXECUTE : FETCH;
            OP_BEQ:       decode_target = BRANCH;
            OP_J:         decode_target = JUMP;
            OP_ADDI:      decode_target = ADDIEX;
            default:      decode_target = FETCH;
        endcase
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                          input logic [5:0] fn, input logic mr);
        case (s)
            FETCH:   next_state = mr ? DECODE : FETCH;
            DECODE:  next_state = decode_target(op, fn);
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = mr ? MEMWB : MEMRD;
            MEMWR:   next_state = mr ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    endfunction

    function automatic logic retires(input state_t s, input logic mr);
        case (s)
            MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: retires = 1'b1;
            MEMWR:                              retires = mr;
            default:                            retires = 1'b0;
        endcase
    endfunction

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= next_state(state_q, Opcode, Funct, MemReady);
            if (retires(state_q, MemReady))
                count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    logic iord_d, memread_d, memwrite_d, irwrite_d, regdst_d, memtoreg_d, regwrite_d;
    logic alusrca_d, pcwrite_d, pcwritecond_d, illegal_d;
    logic [1:0] alusrcb_d, pcsource_d;
    logic [2:0] aluctl_d;

    always_comb begin
        iord_d        = 1'b0;
        memread_d     = 1'b0;
        memwrite_d    = 1'b0;
        irwrite_d     = 1'b0;
        regdst_d      = 1'b0;
        memtoreg_d    = 1'b0;
        regwrite_d    = 1'b0;
        alusrca_d     = 1'b0;
        alusrcb_d     = 2'b00;
        aluctl_d      = ALU_ADD;
        pcsource_d    = 2'b00;
        pcwrite_d     = 1'b0;
        pcwritecond_d = 1'b0;
        illegal_d     = 1'b0;
        case (state_q)
            FETCH: begin
                memread_d = 1'b1;
                alusrcb_d = 2'b01;
                irwrite_d = MemReady;
                pcwrite_d = MemReady;
            end
            DECODE: begin
                alusrcb_d = 2'b11;
                illegal_d = (decode_target(Opcode, Funct) == FETCH);
            end
            MEMADR: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            MEMRD: begin
                memread_d = 1'b1;
                iord_d    = 1'b1;
            end
            MEMWB: begin
                regwrite_d = 1'b1;
                memtoreg_d = 1'b1;
            end
            MEMWR: begin
                memwrite_d = 1'b1;
                iord_d     = 1'b1;
            end
            EXECUTE: begin
                alusrca_d = 1'b1;
                aluctl_d  = funct_alu(Funct);
            end
            ALUWB: begin
                regwrite_d = 1'b1;
                regdst_d   = 1'b1;
            end
            BRANCH: begin
                alusrca_d     = 1'b1;
                aluctl_d      = ALU_SUB;
                pcsource_d    = 2'b01;
                pcwritecond_d = 1'b1;
            end
            JUMP: begin
                pcwrite_d  = 1'b1;
                pcsource_d = 2'b10;
            end
            ADDIEX: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            ADDIWB: begin
                regwrite_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked by ResetN so an asynchronous reset kills them in the same instant.
    assign MemRead    = memread_d  & ResetN;
    assign MemWrite   = memwrite_d & ResetN;
    assign IRWrite    = irwrite_d  & ResetN;
    assign RegWrite   = regwrite_d & ResetN;
    assign PCEn       = (pcwrite_d | (pcwritecond_d & Zero)) & ResetN;
    assign Illegal    = illegal_d  & ResetN;
    assign IorD       = iord_d;
    assign RegDst     = regdst_d;
    assign MemtoReg   = memtoreg_d;
    assign ALUSrcA    = alusrca_d;
    assign ALUSrcB    = alusrcb_d;
    assign ALUControl = aluctl_d;
    assign PCSource   = pcsource_d;
    assign State      = state_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed scenarios plus random instruction
// streams checked cycle by cycle against a per-instruction reference model.
module tb_mips_multicycle_control;

    localparam int CW = 4;

    logic          Clock = 1'b0;
    logic          ResetN;
    logic [5:0]    Opcode, Funct;
    logic          Zero, MemReady;
    logic          IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, PCSource;
    logic [2:0]    ALUControl;
    logic          PCEn, Illegal;
    logic [3:0]    State;
    logic [CW-1:0] InstrCount;

    mips_multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .Clock(Clock), .ResetN(ResetN), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSource(PCSource),
        .PCEn(PCEn), .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
        logic [1:0] pcsrc;
        logic       pcen, illegal;
    } ctl_t;

    typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_ILL} kind_t;

    int passed = 0;
    int total  = 0;
    int cnt    = 0;

    function automatic kind_t kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? K_R : K_ILL;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h08:   return K_ADDI;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(input int st, input logic mr, input logic z,
                                        input logic [5:0] op, input logic [5:0] fn);
        ctl_t e;
        e = '0;
        e.aluctl = 3'b010;
        case (st)
            0:  begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            1:  begin e.alusrcb = 2'b11; e.illegal = (kind(op, fn) == K_ILL); end
            2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            3:  begin e.memread = 1; e.iord = 1; end
            4:  begin e.regwrite = 1; e.memtoreg = 1; end
            5:  begin e.memwrite = 1; e.iord = 1; end
            6:  begin
                    e.alusrca = 1;
                    case (fn)
                        6'h22:   e.aluctl = 3'b110;
                        6'h24:   e.aluctl = 3'b000;
                        6'h25:   e.aluctl = 3'b001;
                        6'h2A:   e.aluctl = 3'b111;
                        default: e.aluctl = 3'b010;
                    endcase
                end
            7:  begin e.regwrite = 1; e.regdst = 1; end
            8:  begin e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            9:  begin e.pcen = 1; e.pcsrc = 2'b10; end
            10: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            11: begin e.regwrite = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctl_t observed();
        ctl_t o;
        o = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, ALUControl, PCSource, PCEn, Illegal};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock of a known expected state: check at negedge, advance model after posedge.
    task automatic step(input int st, input logic mr, input logic z);
        ctl_t e;
        MemReady = mr;
        Zero     = z;
        @(negedge Clock);
        e = expect_ctl(st, mr, z, Opcode, Funct);
        chk($sformatf("state@%0d", st), 32'(State), 32'(st));
        chk($sformatf("ctl@%0d", st), 32'(observed()), 32'(e));
        chk($sformatf("count@%0d", st), 32'(InstrCount), 32'(cnt % (1 << CW)));
        @(posedge Clock);
        #1;
        if (st inside {4, 7, 8, 9, 11} || (st == 5 && mr)) cnt++;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        int   seq[$];
        logic mrq[$];
        kind_t k;
        Opcode = op;
        Funct  = fn;
        k = kind(op, fn);
        for (int i = 0; i < fw; i++) begin seq.push_back(0); mrq.push_back(1'b0); end
        seq.push_back(0); mrq.push_back(1'b1);
        seq.push_back(1); mrq.push_back(1'($urandom));
        case (k)
            K_LW: begin
                seq.push_back(2); mrq.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin seq.push_back(3); mrq.push_back(1'b0); end
                seq.push_back(3); mrq.push_back(1'b1);
                seq.push_back(4); mrq.push_back(1'($urandom));
            end
            K_SW: begin
                seq.push_back(2); mrq.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin seq.push_back(5); mrq.push_back(1'b0); end
                seq.push_back(5); mrq.push_back(1'b1);
            end
            K_R:    begin seq.push_back(6); mrq.push_back(1'b1); seq.push_back(7); mrq.push_back(1'b1); end
            K_BEQ:  begin seq.push_back(8); mrq.push_back(1'($urandom)); end
            K_J:    begin seq.push_back(9); mrq.push_back(1'($urandom)); end
            K_ADDI: begin seq.push_back(10); mrq.push_back(1'b1); seq.push_back(11); mrq.push_back(1'b1); end
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++)
            step(seq[i], mrq[i], (seq[i] == 8) ? z : 1'($urandom));
    endtask

    task automatic reset_check(input string tag);
        ctl_t r;
        r = '0;
        r.alusrcb = 2'b01;
        r.aluctl  = 3'b010;
        chk({tag, "_state"}, 32'(State), 32'd0);
        chk({tag, "_ctl"}, 32'(observed()), 32'(r));
        chk({tag, "_count"}, 32'(InstrCount), 32'd0);
    endtask

    logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};
    logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};

    initial begin
        ResetN = 1'b0; MemReady = 1'b1; Zero = 1'b1; Opcode = 6'h00; Funct = 6'h20;
        repeat (2) @(posedge Clock);
        #1;
        reset_check("reset");
        ResetN = 1'b1;
        cnt = 0;

        run_instr(6'h00, 6'h20, 0, 0, 1'b0);                  // add
        chk("add_count", 32'(InstrCount), 32'd1);
        run_instr(6'h23, 6'h00, 0, 2, 1'b0);                  // lw, two wait states
        run_instr(6'h04, 6'h00, 0, 0, 1'b1);                  // beq taken
        run_instr(6'h04, 6'h00, 1, 0, 1'b0);                  // beq not taken, fetch wait
        run_instr(6'h00, 6'h2A, 0, 0, 1'b0);                  // slt
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0);                  // illegal opcode
        run_instr(6'h00, 6'h3F, 0, 0, 1'b0);                  // illegal funct
        run_instr(6'h2B, 6'h00, 0, 1, 1'b0);                  // sw, one wait state
        run_instr(6'h08, 6'h00, 2, 0, 1'b0);                  // addi

        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(7)], fns[$urandom_range(6)],
                      $urandom_range(2), $urandom_range(3), 1'($urandom));

        if ((cnt % (1 << CW)) == 0) run_instr(6'h02, 6'h00, 0, 0, 1'b0);
        Opcode = 6'h2B; Funct = 6'h00;
        step(0, 1'b1, 1'b0);
        step(1, 1'b1, 1'b0);
        step(2, 1'b1, 1'b0);
        MemReady = 1'b0;
        @(negedge Clock);
        chk("memwr_state", 32'(State), 32'd5);
        chk("memwr_we", 32'(MemWrite), 32'd1);
        #2 ResetN = 1'b0;
        #1;
        reset_check("async_reset");
        cnt = 0;
        @(posedge Clock);
        #1 ResetN = 1'b1;

        for (int n = 0; n < 15; n++) run_instr(6'h02, 6'h00, 0, 0, 1'b0);
        chk("count_15", 32'(InstrCount), 32'd15);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0);
        chk("count_wrap", 32'(InstrCount), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
